pipelined_alu_core: RTL and testbench

Parametrised two-stage successor to the single-cycle register-file/ALU datapath. It accepts 3-bit-opcode register-register instructions over a valid/ready handshake and reads operands in stage 1. It executes and writes back in stage 2, presenting each result on muxout with a valid strobe. Register count, data width and field widths are generic; the optional bypass path removes read-after-write stalls.

---
 rtl/alu_core_pkg.sv | 65 ++++++
 rtl/alu_unit.sv | 29 ++
 rtl/pipelined_alu_core.sv | 102 ++++++++++
 tb/tb_pipelined_alu_core.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_core_pkg.sv
// Shared definitions for the pipelined ALU core: opcodes, instruction field helpers and the decoded-instruction type.
// Optional operand forwarding in the core is enabled by defining ALU_FORWARD_EN.
package alu_core_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_AND  = 3'b001,
        OP_NAND = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SGT  = 3'b101,
        OP_SLL  = 3'b110,
        OP_SRL  = 3'b111
    } op_t;

    // Helpers work on a widest-case container; cores narrow the fields back to RADDR_W.
    localparam int MAX_RADDR_W = 8;
    localparam int MAX_INSTR_W = 3 + 3 * MAX_RADDR_W;

    typedef logic [MAX_INSTR_W-1:0] instr_t;
    typedef logic [MAX_RADDR_W-1:0] raddr_t;

    typedef struct packed {
        op_t    op;
        raddr_t rd;
        raddr_t rs;
        raddr_t rt;
    } dec_t;

    function automatic raddr_t field_at(input instr_t ins, input int raddr_w, input int pos);
        instr_t mask;
        mask = (instr_t'(1) << raddr_w) - instr_t'(1);
        return raddr_t'((ins >> (pos * raddr_w)) & mask);
    endfunction

    function automatic op_t field_op(input instr_t ins, input int raddr_w);
        return op_t'(3'(ins >> (3 * raddr_w)));
    endfunction

    function automatic raddr_t field_rd(input instr_t ins, input int raddr_w);
        return field_at(ins, raddr_w, 2);
    endfunction

    function automatic raddr_t field_rs(input instr_t ins, input int raddr_w);
        return field_at(ins, raddr_w, 1);
    endfunction

    function automatic raddr_t field_rt(input instr_t ins, input int raddr_w);
        return field_at(ins, raddr_w, 0);
    endfunction

    function automatic dec_t decode(input instr_t ins, input int raddr_w);
        dec_t d;
        d.op = field_op(ins, raddr_w);
        d.rd = field_rd(ins, raddr_w);
        d.rs = field_rs(ins, raddr_w);
        d.rt = field_rt(ins, raddr_w);
        return d;
    endfunction

    function automatic logic is_shift(input op_t op);
        return (op == OP_SLL) || (op == OP_SRL);
    endfunction

endpackage

// File: rtl/alu_unit.sv
// Combinational ALU: op x A x B -> result. For shifts B carries the immediate amount.
module alu_unit
    import alu_core_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  op_t               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_AND:  y = a & b;
            OP_NAND: y = ~(a & b);
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SGT:  y = {{(DATA_W-1){1'b0}}, ($signed(a) > $signed(b))};
            // Shift amounts >= DATA_W already yield zero under these operators.
            OP_SLL:  y = a << b;
            OP_SRL:  y = a >> b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/pipelined_alu_core.sv
// Two-stage register-file/ALU core: S1 reads operands, S2 executes and writes back.
// Define ALU_FORWARD_EN to forward S1's result into operand capture instead of stalling.
module pipelined_alu_core
    import alu_core_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int RADDR_W = 5,
    parameter  int CNT_W   = 16,
    localparam int INSTR_W = 3 + 3 * RADDR_W
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instruct,
    output logic               out_valid,
    output logic [DATA_W-1:0]  muxout,
    output logic [RADDR_W-1:0] out_rd,
    output logic [CNT_W-1:0]   retired
);

    localparam int NREGS = 2 ** RADDR_W;

    logic [DATA_W-1:0] regs [NREGS];

    op_t                in_op;
    logic [RADDR_W-1:0] in_rd, in_rs, in_rt;
    logic               in_shift;

    logic               s1_valid;
    op_t                s1_op;
    logic [RADDR_W-1:0] s1_rd;
    logic [DATA_W-1:0]  s1_a, s1_b;
    logic [DATA_W-1:0]  alu_y;

    logic               hit_a, hit_b, accept;
    logic [DATA_W-1:0]  opnd_a, opnd_b;

    assign in_op    = field_op(instr_t'(instruct), RADDR_W);
    assign in_rd    = RADDR_W'(field_rd(instr_t'(instruct), RADDR_W));
    assign in_rs    = RADDR_W'(field_rs(instr_t'(instruct), RADDR_W));
    assign in_rt    = RADDR_W'(field_rt(instr_t'(instruct), RADDR_W));
    assign in_shift = is_shift(in_op);

    // Read-after-write against the instruction held in S1; write-after-write is harmless.
    assign hit_a = s1_valid && (s1_rd == in_rs);
    assign hit_b = s1_valid && !in_shift && (s1_rd == in_rt);

    always_comb begin
        opnd_a   = regs[in_rs];
        opnd_b   = in_shift ? DATA_W'(in_rt) : regs[in_rt];
        in_ready = reset_n;
`ifdef ALU_FORWARD_EN
        if (hit_a) opnd_a = alu_y;
        if (hit_b) opnd_b = alu_y;
`else
        if (hit_a || hit_b) in_ready = 1'b0;
`endif
    end

    assign accept = in_valid && in_ready;

    alu_unit #(.DATA_W(DATA_W)) u_alu (
        .op (s1_op),
        .a  (s1_a),
        .b  (s1_b),
        .y  (alu_y)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= DATA_W'(i);
            end
            s1_valid  <= 1'b0;
            s1_op     <= OP_ADD;
            s1_rd     <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
            out_valid <= 1'b0;
            muxout    <= '0;
            out_rd    <= '0;
            retired   <= '0;
        end else begin
            s1_valid  <= accept;
            out_valid <= s1_valid;
            if (accept) begin
                s1_op <= in_op;
                s1_rd <= in_rd;
                s1_a  <= opnd_a;
                s1_b  <= opnd_b;
            end
            if (s1_valid) begin
                regs[s1_rd] <= alu_y;
                muxout      <= alu_y;
                out_rd      <= s1_rd;
                if (retired != '1) retired <= retired + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipelined_alu_core.sv
// Directed scoreboard bench for pipelined_alu_core (default 32-bit core plus a 16-bit, 2-bit-counter instance).
module tb_pipelined_alu_core;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] instruct;
    logic        out_valid;
    logic [31:0] muxout;
    logic [4:0]  out_rd;
    logic [15:0] retired;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [17:0] b_instruct;
    logic        b_out_valid;
    logic [15:0] b_muxout;
    logic [4:0]  b_out_rd;
    logic [1:0]  b_retired;

    always #5 clock = ~clock;

    pipelined_alu_core dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instruct  (instruct),
        .out_valid (out_valid),
        .muxout    (muxout),
        .out_rd    (out_rd),
        .retired   (retired)
    );

    pipelined_alu_core #(.DATA_W(16), .RADDR_W(5), .CNT_W(2)) dut16 (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .instruct  (b_instruct),
        .out_valid (b_out_valid),
        .muxout    (b_muxout),
        .out_rd    (b_out_rd),
        .retired   (b_retired)
    );

`ifdef ALU_FORWARD_EN
    localparam int EXP_STALLS = 0;
    localparam int EXP_SPAN   = 8;
`else
    localparam int EXP_STALLS = 5;
    localparam int EXP_SPAN   = 13;
`endif

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] v;
    } exp_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          stalls = 0;
    int          acc_cyc = 0;
    int          last_out = 0;
    int          exp_ret = 0;
    exp_t        q[$];
    logic [31:0] obs_log[$];
    logic [31:0] mdl[32];

    always @(posedge clock) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] mk(input logic [2:0] op, input int rd, input int rs, input int rt);
        return {op, 5'(rd), 5'(rs), 5'(rt)};
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a & b;
            3'd2: return ~(a & b);
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
            3'd6: return a << b;
            default: return a >> b;
        endcase
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 32; i++) mdl[i] = 32'(i);
        q.delete();
        exp_ret = 0;
    endtask

    // Program-order model: result is what a sequential machine would write.
    task automatic push_expected(input logic [17:0] ins);
        logic [2:0]  op;
        logic [31:0] a, b, r;
        exp_t        e;
        op = ins[17:15];
        a  = mdl[ins[9:5]];
        b  = (op == 3'd6 || op == 3'd7) ? {27'b0, ins[4:0]} : mdl[ins[4:0]];
        r  = ref_alu(op, a, b);
        mdl[ins[14:10]] = r;
        e.rd = ins[14:10];
        e.v  = r;
        q.push_back(e);
    endtask

    task automatic send(input logic [17:0] ins);
        int n;
        n = 0;
        instruct = ins;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 8) begin
            stalls++;
            @(negedge clock);
            #1;
            n++;
        end
        if (!in_ready) chk("accept_timeout", {31'b0, in_ready}, 32'd1);
        push_expected(ins);
        @(negedge clock);
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 30) begin
            @(negedge clock);
            #2;
            n++;
        end
        chk("drain_left", 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        b_in_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("in_ready_in_reset", {31'b0, in_ready}, 32'd0);
        reset_n = 1'b1;
        reset_model();
    endtask

    always @(negedge clock) begin : mon
        exp_t e;
        if (reset_n && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("muxout", muxout, e.v);
                chk("out_rd", 32'(out_rd), 32'(e.rd));
                exp_ret++;
                obs_log.push_back(muxout);
                last_out = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          first_acc;
        int          s0;
        logic [31:0] stream_exp[8];
        stream_exp = '{32'hFFFFFFFF, 32'hF, 32'h7, 32'h8, 32'hE, 32'hE, 32'h1D, 32'h1};
        instruct   = '0;
        b_instruct = '0;

        // Reset state
        do_reset();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_muxout", muxout, 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);

        // Single NAND R3,R1,R2: result visible one edge after accept, then a bubble
        send(mk(3'd2, 3, 1, 2));
        @(negedge clock);
        #1;
        chk("t1_out_valid", {31'b0, out_valid}, 32'd1);
        chk("t1_muxout", muxout, 32'hFFFFFFFF);
        chk("t1_out_rd", 32'(out_rd), 32'd3);
        chk("t1_retired", 32'(retired), 32'd1);
        @(negedge clock);
        #1;
        chk("t1_bubble", {31'b0, out_valid}, 32'd0);

        // Dependent back-to-back stream
        do_reset();
        obs_log.delete();
        stalls = 0;
        send(mk(3'd2, 3, 1, 2));
        first_acc = acc_cyc;
        send(mk(3'd7, 4, 3, 28));
        send(mk(3'd7, 5, 4, 1));
        send(mk(3'd4, 1, 4, 5));
        send(mk(3'd6, 2, 5, 1));
        send(mk(3'd3, 6, 1, 2));
        send(mk(3'd0, 7, 4, 6));
        send(mk(3'd5, 8, 4, 6));
        drain();
        chk("stream_stalls", 32'(stalls), 32'(EXP_STALLS));
        chk("stream_span", 32'(last_out - first_acc), 32'(EXP_SPAN));
        chk("stream_retired", 32'(retired), 32'd8);
        chk("stream_count", 32'(obs_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < obs_log.size(); i++) chk($sformatf("stream_val%0d", i), obs_log[i], stream_exp[i]);

        // Shift boundary and signed compare
        obs_log.delete();
        send(mk(3'd6, 9, 5, 31));
        send(mk(3'd2, 10, 0, 0));
        send(mk(3'd7, 11, 10, 31));
        send(mk(3'd5, 12, 10, 11));
        send(mk(3'd5, 12, 11, 10));
        drain();
        chk("sll31", obs_log[0], 32'h80000000);
        chk("sgt_neg_pos", obs_log[3], 32'd0);
        chk("sgt_pos_neg", obs_log[4], 32'd1);

        // Write-after-write and shift rt field never stall
        s0 = stalls;
        send(mk(3'd0, 13, 1, 2));
        send(mk(3'd0, 13, 0, 0));
        send(mk(3'd6, 14, 0, 13));
        drain();
        chk("no_false_hazard", 32'(stalls - s0), 32'd0);
        chk("retired_total", 32'(retired), 32'(exp_ret));

        // Reset while X sits in S1 and Y is being presented
        send(mk(3'd2, 3, 1, 2));
        instruct = mk(3'd0, 4, 3, 3);
        in_valid = 1'b1;
        reset_n  = 1'b0;
        #1;
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        q.delete();
        @(negedge clock);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        reset_model();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("midrst_no_out", {31'b0, out_valid}, 32'd0);
            @(negedge clock);
        end
        chk("midrst_retired", 32'(retired), 32'd0);
        chk("midrst_muxout", muxout, 32'd0);
        obs_log.delete();
        send(mk(3'd0, 13, 3, 0));
        drain();
        chk("midrst_r3", obs_log[0], 32'd3);

        // 16-bit core: oversize shift and counter saturation
        @(negedge clock);
        b_instruct = mk(3'd7, 1, 31, 20);
        b_in_valid = 1'b1;
        #1;
        chk("b_ready", {31'b0, b_in_ready}, 32'd1);
        @(negedge clock);
        b_instruct = mk(3'd7, 2, 31, 3);
        @(negedge clock);
        b_instruct = mk(3'd6, 3, 31, 12);
        #1;
        chk("b_srl20_valid", {31'b0, b_out_valid}, 32'd1);
        chk("b_srl20", 32'(b_muxout), 32'd0);
        chk("b_srl20_rd", 32'(b_out_rd), 32'd1);
        @(negedge clock);
        b_instruct = mk(3'd0, 4, 0, 0);
        #1;
        chk("b_srl3", 32'(b_muxout), 32'd3);
        @(negedge clock);
        b_in_valid = 1'b0;
        #1;
        chk("b_sll12", 32'(b_muxout), 32'hF000);
        chk("b_retired3", 32'(b_retired), 32'd3);
        @(negedge clock);
        #1;
        chk("b_add_valid", {31'b0, b_out_valid}, 32'd1);
        chk("b_add", 32'(b_muxout), 32'd0);
        chk("b_retired_sat", 32'(b_retired), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
